// File: rtl/lfsr_stim_gen.sv
// Test-wrapper stimulus source: registers external {func,data} words or emits a
// maximal-length Fibonacci LFSR sequence, stopping (sticky) on a programmable stop code.
module lfsr_stim_gen #(
  parameter int unsigned            DATA_WIDTH = 49,
  parameter logic [DATA_WIDTH-1:0]  SEED       = 49'h1,
  parameter logic [DATA_WIDTH-1:0]  TAPS       = 49'h1_0080_0000_0000,
  parameter int unsigned            CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst_n,
  input  logic                  i_mode,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_seed_ld,
  input  logic [DATA_WIDTH-1:0] i_stop_code,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_dbg_state
);

  // Handshake: o_vld is a one-cycle qualifier for o_data with no back-pressure;
  // i_vld means "word valid" in mode 0 and "advance LFSR" in mode 1.

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   lfsr, lfsr_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    vld_nxt;
  logic [CNT_WIDTH-1:0]    cnt_nxt;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic                    fb;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state   <= ST_RUN;
      lfsr    <= SEED;
      o_vld   <= 1'b0;
      o_data  <= '0;
      o_count <= '0;
    end else begin
      state   <= state_nxt;
      lfsr    <= lfsr_nxt;
      o_vld   <= vld_nxt;
      o_data  <= data_nxt;
      o_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    vld_nxt   = 1'b0;
    data_nxt  = o_data;
    cnt_nxt   = o_count;
    fb        = ^(lfsr & TAPS);
    cnt_inc   = (&o_count) ? o_count : o_count + CNT_ONE;

    if (i_seed_ld && i_mode) begin
      // A zero seed would lock the LFSR, so it falls back to SEED.
      lfsr_nxt  = (i_data == '0) ? SEED : i_data;
      cnt_nxt   = '0;
      state_nxt = ST_RUN;
    end else if (state == ST_DONE) begin
      vld_nxt = 1'b0;
    end else if (!i_mode) begin
      vld_nxt = i_vld;
      if (i_vld) begin
        data_nxt = i_data;
        cnt_nxt  = cnt_inc;
        if (i_data == i_stop_code) state_nxt = ST_DONE;
      end
    end else if (i_vld) begin
      data_nxt = lfsr;
      vld_nxt  = 1'b1;
      cnt_nxt  = cnt_inc;
      lfsr_nxt = {lfsr[DATA_WIDTH-2:0], fb};
      if (lfsr == i_stop_code) state_nxt = ST_DONE;
    end
  end

  assign o_done      = (state == ST_DONE);
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Self-checking bench for lfsr_stim_gen: emitted words are scored against an
// expected queue; status outputs are checked against bench-derived constants.
module tb_lfsr_stim_gen;

  localparam int W = 49;
  localparam logic [W-1:0] STOP2 = 49'h1_2345_6789_ABCD;
  localparam logic [W-1:0] NO_STOP = 49'h1_FFFF_FFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          mode;
  logic          vld;
  logic [W-1:0]  data;
  logic          seed_ld;
  logic [W-1:0]  stop;

  logic          o_vld, o_done, o_dbg;
  logic [W-1:0]  o_data;
  logic [31:0]   o_count;
  logic          d4_vld, d4_done, d4_dbg;
  logic [W-1:0]  d4_data;
  logic [3:0]    d4_count;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  m_lfsr;
  logic [W-1:0]  last_word;
  logic [W-1:0]  one;
  int            m_cnt;
  int            n_checks;
  int            n_errors;

  lfsr_stim_gen dut (
    .i_clk(clk), .i_async_rst_n(rst_n), .i_mode(mode), .i_vld(vld),
    .i_data(data), .i_seed_ld(seed_ld), .i_stop_code(stop),
    .o_vld(o_vld), .o_data(o_data), .o_done(o_done), .o_count(o_count),
    .o_dbg_state(o_dbg)
  );

  lfsr_stim_gen #(.CNT_WIDTH(4)) dut4 (
    .i_clk(clk), .i_async_rst_n(rst_n), .i_mode(mode), .i_vld(vld),
    .i_data(data), .i_seed_ld(seed_ld), .i_stop_code(stop),
    .o_vld(d4_vld), .o_data(d4_data), .o_done(d4_done), .o_count(d4_count),
    .o_dbg_state(d4_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // golden x^49 + x^40 + 1 step written from the tap positions
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], s[48] ^ s[39]};
  endfunction

  // drivers
  task automatic adv(input int n);
    mode = 1'b1;
    vld  = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_lfsr);
      last_word = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 49'h1;
    m_cnt  = 0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && o_vld) begin
      if (exp_q.size() == 0) check_val("spurious_vld", o_vld, 1'b0);
      else check_val("word", o_data, exp_q.pop_front());
    end
  end

  logic [W-1:0] t2_dat [8];
  logic         t2_vld [8];

  initial begin
    logic emit;
    logic done_m;
    n_checks = 0;
    n_errors = 0;
    one = 49'h1;
    m_lfsr = 49'h1;
    m_cnt = 0;
    last_word = '0;

    // Test 1: reset state, then internal run to stop code 8
    rst_n = 1'b0; mode = 1'b1; vld = 1'b1; data = '0; seed_ld = 1'b0; stop = 49'h8;
    repeat (2) @(negedge clk);
    check_val("rst_vld", o_vld, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_count", o_count, 0);
    check_val("rst_state", o_dbg, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(one << i);
      @(negedge clk);
    end
    check_val("t1_done", o_done, 1);
    check_val("t1_state", o_dbg, 1);
    check_val("t1_count", o_count, 4);
    @(negedge clk);
    check_val("t1_vld_drop", o_vld, 0);
    check_val("t1_frozen_data", o_data, 49'h8);
    check_val("t1_frozen_count", o_count, 4);
    check_val("t1_done_sticky", o_done, 1);
    #1 check_val("t1_q_empty", exp_q.size(), 0);

    // Test 2: external passthrough with gaps and stop word
    mode = 1'b0; vld = 1'b0; stop = STOP2;
    pulse_reset();
    t2_vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t2_dat = '{49'h5, 49'h0, 49'hA, 49'h0, 49'h0, STOP2, 49'h77, 49'h0};
    done_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld  = t2_vld[i];
      data = t2_vld[i] ? t2_dat[i] : 49'($urandom_range(1, 1000));
      emit = vld && !done_m;
      if (emit) exp_q.push_back(data);
      @(negedge clk);
      check_val("t2_vld", o_vld, emit);
      if (emit && data == STOP2) done_m = 1'b1;
    end
    check_val("t2_done", o_done, 1);
    check_val("t2_count", o_count, 3);
    check_val("t2_hold_data", o_data, STOP2);

    // Test 3: seed load of zero from DONE falls back to SEED
    mode = 1'b1; vld = 1'b1; seed_ld = 1'b1; data = '0; stop = NO_STOP;
    @(negedge clk);
    seed_ld = 1'b0;
    check_val("t3_done_clr", o_done, 0);
    check_val("t3_count_clr", o_count, 0);
    check_val("t3_vld", o_vld, 0);
    m_lfsr = 49'h1;
    m_cnt  = 0;
    adv(1);
    check_val("t3_first", o_data, 49'h1);

    // Test 4: long run through the tap region, then mode toggling
    for (int k = 2; k <= 50; k++) begin
      adv(1);
      if (k == 40) check_val("t4_w40", o_data, one << 39);
    end
    check_val("t4_count", o_count, m_cnt);
    mode = 1'b1; vld = 1'b0;
    @(negedge clk);
    check_val("t4_idle_vld", o_vld, 0);
    check_val("t4_idle_hold", o_data, last_word);
    mode = 1'b0; vld = 1'b0; data = 49'h3C;
    repeat (2) @(negedge clk);
    vld = 1'b1; seed_ld = 1'b1; data = 49'h55;
    exp_q.push_back(data);
    m_cnt++;
    @(negedge clk);
    seed_ld = 1'b0;
    check_val("t4_ext_count", o_count, m_cnt);
    adv(3);
    check_val("t4_resume_count", o_count, m_cnt);

    // Test 5: asynchronous reset between edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("t5_vld", o_vld, 0);
    check_val("t5_data", o_data, 0);
    check_val("t5_done", o_done, 0);
    check_val("t5_count", o_count, 0);
    check_val("t5_d4_count", d4_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 49'h1;
    m_cnt  = 0;
    adv(1);
    check_val("t5_restart", o_data, 49'h1);

    // Test 6: narrow counter saturation and mode toggle mid-run
    adv(13);
    check_val("t6_d4_14", d4_count, 14);
    adv(6);
    check_val("t6_d4_sat", d4_count, 15);
    check_val("t6_count20", o_count, 20);
    mode = 1'b0; vld = 1'b1; data = 49'h9;
    exp_q.push_back(data);
    @(negedge clk);
    check_val("t6_d4_hold", d4_count, 15);
    adv(2);
    check_val("t6_d4_still", d4_count, 15);
    check_val("t6_count23", o_count, 23);
    vld = 1'b0;
    @(negedge clk);
    #1 check_val("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
